// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with prescaler, auto-reload
// and a level interrupt. Four word registers at BASE_ADDR..BASE_ADDR+3:
// CTRL (RW), LOAD (RW), COUNT (RO), STATUS (RW1C). Reads have one cycle of
// latency, matching the RAM they share the CPU read mux with.
module mmio_timer #(
   parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] ADDR,
   input  logic [15:0] DATA_I,
   input  logic        RD,
   input  logic        WR,
   output logic [15:0] DATA_O,
   output logic        SEL,
   output logic        IRQ
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // CTRL implemented bits: PRE[15:8], IE[2], AR[1], EN[0]
   localparam logic [15:0] CTRL_MASK = 16'hFF07;

   state_t      state_q, state_d;
   logic [15:0] ctrl_q, ctrl_d;
   logic [15:0] load_q, load_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  pre_cnt_q, pre_cnt_d;
   logic        exp_q, exp_d;
   logic [15:0] data_o_q, data_o_d;
   logic        sel_q, sel_d;

   // 17-bit subtraction so addresses below BASE_ADDR cannot alias into the window
   logic [16:0] addr_diff;
   logic        hit;
   logic [1:0]  reg_idx;
   logic        wr_ctrl, wr_load, wr_stat, rd_hit;
   logic [15:0] rdata;

   assign addr_diff = {1'b0, ADDR} - {1'b0, BASE_ADDR};
   assign hit       = (addr_diff[16:2] == 15'd0);
   assign reg_idx   = addr_diff[1:0];
   assign wr_ctrl   = WR && hit && (reg_idx == 2'd0);
   assign wr_load   = WR && hit && (reg_idx == 2'd1);
   assign wr_stat   = WR && hit && (reg_idx == 2'd3);
   // a simultaneous write suppresses the read
   assign rd_hit    = RD && !WR && hit;

   // Read mux: samples register contents before this edge's updates
   always_comb begin
      rdata = 16'h0000;
      case (reg_idx)
         2'd0:    rdata = ctrl_q;
         2'd1:    rdata = load_q;
         2'd2:    rdata = count_q;
         default: rdata = {15'd0, exp_q};
      endcase
   end

   // Next-state: register writes, timer FSM, prescaler and expiry
   always_comb begin
      state_d   = state_q;
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      count_d   = count_q;
      pre_cnt_d = pre_cnt_q;
      exp_d     = exp_q;
      sel_d     = rd_hit;
      data_o_d  = rd_hit ? rdata : 16'h0000;

      if (wr_load) load_d = DATA_I;
      if (wr_ctrl) ctrl_d = DATA_I & CTRL_MASK;
      // expiry below is assigned later so it wins over a same-cycle clear
      if (wr_stat && DATA_I[0]) exp_d = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (wr_ctrl && DATA_I[0]) begin
               state_d   = RUN;
               count_d   = load_q;
               pre_cnt_d = 8'd0;
            end
         end
         RUN: begin
            if (wr_ctrl && !DATA_I[0]) begin
               // stop takes priority over a coincident tick; COUNT holds
               state_d = IDLE;
            end else if (pre_cnt_q == ctrl_q[15:8]) begin
               pre_cnt_d = 8'd0;
               if (count_q != 16'd0) begin
                  count_d = count_q - 16'd1;
               end else begin
                  exp_d = 1'b1;
                  if (ctrl_q[1]) begin
                     count_d = load_q;
                  end else begin
                     state_d   = DONE;
                     ctrl_d[0] = 1'b0;
                  end
               end
            end else begin
               pre_cnt_d = pre_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset overriding any bus activity
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         ctrl_q    <= 16'h0000;
         load_q    <= 16'h0000;
         count_q   <= 16'h0000;
         pre_cnt_q <= 8'd0;
         exp_q     <= 1'b0;
         data_o_q  <= 16'h0000;
         sel_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         pre_cnt_q <= pre_cnt_d;
         exp_q     <= exp_d;
         data_o_q  <= data_o_d;
         sel_q     <= sel_d;
      end
   end

   assign DATA_O = data_o_q;
   assign SEL    = sel_q;
   assign IRQ    = exp_q & ctrl_q[2];

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard bench. Every driven cycle pushes the expected
// {SEL,DATA_O} (and optionally IRQ) for the following edge; a monitor pops
// and compares 1 time unit after each rising edge.
module tb_mmio_timer;

   localparam logic [15:0] BASE = 16'hFF00;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] ADDR = 16'h0000;
   logic [15:0] DATA_I = 16'h0000;
   logic        RD = 1'b0;
   logic        WR = 1'b0;
   logic [15:0] DATA_O;
   logic        SEL;
   logic        IRQ;

   mmio_timer #(.BASE_ADDR(BASE)) dut (
      .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA_I(DATA_I),
      .RD(RD), .WR(WR), .DATA_O(DATA_O), .SEL(SEL), .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      bit          is_irq;
      logic [16:0] val;
      int          due;
   } sb_t;

   sb_t sb[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp_v);
      end
   endtask

   // monitor: compare entries whose due cycle is the edge just passed
   initial begin
      sb_t e;
      forever begin
         @(posedge CLK);
         #1;
         cyc++;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.is_irq) chk(e.tag, {31'd0, IRQ}, {31'd0, e.val[0]});
            else          chk(e.tag, {15'd0, SEL, DATA_O}, {15'd0, e.val});
         end
      end
   end

   task automatic exp_irq(input logic v, input string tag);
      sb_t e;
      e.tag = tag; e.is_irq = 1'b1; e.val = {16'd0, v}; e.due = cyc + 1;
      sb.push_back(e);
   endtask

   // one bus cycle: drive at the falling edge, expect read port after next rise
   task automatic drv(input logic rst, input logic rd, input logic wr,
                      input logic [15:0] a, input logic [15:0] d,
                      input logic esel, input logic [15:0] edat, input string tag);
      sb_t e;
      RST = rst; RD = rd; WR = wr; ADDR = a; DATA_I = d;
      e.tag = tag; e.is_irq = 1'b0; e.val = {esel, edat}; e.due = cyc + 1;
      sb.push_back(e);
      @(negedge CLK);
   endtask

   task automatic wr(input int off, input logic [15:0] d);
      drv(1'b0, 1'b0, 1'b1, BASE + 16'(off), d, 1'b0, 16'h0000, "wr_sel_low");
   endtask

   task automatic rd(input int off, input logic [15:0] ev, input string tag);
      drv(1'b0, 1'b1, 1'b0, BASE + 16'(off), 16'h0000, 1'b1, ev, tag);
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "idle_sel_low");
   endtask

   initial begin
      // initial reset
      exp_irq(1'b0, "irq_reset");
      drv(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "reset0");
      drv(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "reset1");
      rd(0, 16'h0000, "ctrl_after_reset");
      rd(2, 16'h0000, "count_after_reset");

      // readback, miss, CTRL reserved bits
      wr(1, 16'h1234);
      rd(1, 16'h1234, "load_readback");
      drv(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, "read_miss");
      drv(1'b0, 1'b1, 1'b0, BASE + 16'd4, 16'h0000, 1'b0, 16'h0000, "read_miss_above");
      idle();
      wr(0, 16'hABF8);
      rd(0, 16'hAB00, "ctrl_reserved_bits");
      wr(0, 16'h0000);

      // one-shot: LOAD=3, EN+IE, PRE=0
      wr(1, 16'd3);
      wr(0, 16'h0005);
      rd(2, 16'd3, "oneshot_cnt3");
      rd(2, 16'd2, "oneshot_cnt2");
      exp_irq(1'b0, "oneshot_irq_pre");
      rd(2, 16'd1, "oneshot_cnt1");
      exp_irq(1'b1, "oneshot_irq_rise");
      rd(2, 16'd0, "oneshot_cnt0");
      rd(3, 16'h0001, "oneshot_exp");
      rd(0, 16'h0004, "oneshot_ctrl_en_clr");
      idle();
      rd(2, 16'd0, "oneshot_done_hold");
      exp_irq(1'b0, "oneshot_irq_w1c");
      wr(3, 16'h0001);
      idle();
      rd(3, 16'h0000, "done_no_reexpire");

      // auto-reload with prescale: LOAD=1, PRE=1 -> expiry every 4 cycles
      wr(1, 16'd1);
      wr(0, 16'h0103);
      rd(3, 16'h0000, "ar_e1");
      rd(3, 16'h0000, "ar_e2");
      rd(3, 16'h0000, "ar_e3");
      exp_irq(1'b0, "ar_irq_ie_off");
      rd(3, 16'h0000, "ar_e4");
      rd(3, 16'h0001, "ar_exp1");
      wr(3, 16'h0001);
      rd(3, 16'h0000, "ar_cleared");
      rd(3, 16'h0000, "ar_e8");
      rd(3, 16'h0001, "ar_exp2");
      wr(3, 16'h0001);
      rd(3, 16'h0000, "ar_cleared2");
      wr(3, 16'h0001);
      rd(3, 16'h0001, "ar_w1c_vs_expiry");
      exp_irq(1'b1, "ar_irq_ie_on");
      wr(0, 16'h0107);
      exp_irq(1'b0, "ar_irq_w1c");
      wr(3, 16'h0001);
      exp_irq(1'b1, "ar_irq_undisturbed");
      idle();
      wr(0, 16'h0000);
      exp_irq(1'b0, "ar_irq_stop");
      wr(3, 16'h0001);

      // LOAD=0, AR, PRE=0: expiry every cycle
      wr(1, 16'h0000);
      wr(0, 16'h0003);
      rd(3, 16'h0000, "l0_first");
      wr(3, 16'h0001);
      rd(3, 16'h0001, "l0_every_cycle");
      wr(3, 16'h0001);
      rd(3, 16'h0001, "l0_every_cycle2");
      wr(0, 16'h0000);
      wr(3, 16'h0001);
      rd(3, 16'h0000, "l0_stopped_clear");

      // stop / start
      wr(1, 16'd8);
      wr(0, 16'h0001);
      idle();
      idle();
      idle();
      wr(0, 16'h0000);
      rd(2, 16'd5, "stop_hold5");
      idle();
      idle();
      rd(2, 16'd5, "stop_hold5_later");
      wr(1, 16'd20);
      wr(0, 16'h0001);
      rd(2, 16'd20, "start_reload");
      wr(1, 16'd100);
      rd(2, 16'd18, "load_wr_during_run");
      wr(0, 16'h0000);
      rd(1, 16'd100, "load_next");

      // RD and WR together
      drv(1'b0, 1'b1, 1'b1, BASE + 16'd1, 16'hBEEF, 1'b0, 16'h0000, "rdwr_sel_low");
      rd(1, 16'hBEEF, "rdwr_load");

      // reset mid-run with bus activity
      wr(1, 16'd2);
      wr(0, 16'h0007);
      idle();
      idle();
      exp_irq(1'b1, "pre_reset_irq");
      idle();
      exp_irq(1'b0, "reset_irq");
      drv(1'b1, 1'b0, 1'b1, BASE, 16'hFFFF, 1'b0, 16'h0000, "reset_wr");
      drv(1'b1, 1'b1, 1'b0, BASE + 16'd1, 16'h0000, 1'b0, 16'h0000, "reset_rd");
      rd(0, 16'h0000, "rst_ctrl");
      rd(1, 16'h0000, "rst_load");
      rd(2, 16'h0000, "rst_count");
      rd(3, 16'h0000, "rst_status");
      for (int i = 0; i < 5; i++) idle();
      exp_irq(1'b0, "rst_idle_irq");
      rd(3, 16'h0000, "rst_idle_status");
      idle();

      begin
         int k = 0;
         while (sb.size() != 0 && k < 20) begin
            @(negedge CLK);
            k++;
         end
         chk("scoreboard_drain", 32'(sb.size()), 32'd0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
